alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (3-bit function code: AND, OR, ADD, XOR, NOR, SUB, SLT) between NUM_REQ requesters.
- Each requester has a valid/ready request port and a valid/ready response port.
- Grant is round-robin. The winner's operands are registered, driven onto the ALU for one cycle, and the result and flags are captured and held until the requester accepts them.
- Sits between the pipeline and coprocessor units and the single ALU instance.

Parameters:
- WIDTH, 16, operand and result width; must match the attached ALU.
- NUM_REQ, 4, number of requesters; 2..8.
- IDW, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand b, same packing as req_a
- req_f  in  NUM_REQ*3  function code; requester i occupies bits [i*3 +: 3]
- resp_valid  out  NUM_REQ  one-hot response valid to the owning requester
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_y  out  WIDTH  result, shared by all requesters
- resp_zero  out  1  captured zero flag
- resp_carry  out  1  captured carry_out flag
- resp_ovf  out  1  captured overflow flag
- resp_err  out  1  1 when the function code was the illegal 3'b011
- resp_id  out  IDW  index of the requester that owns the response
- alu_a  out  WIDTH  operand a to the shared ALU
- alu_b  out  WIDTH  operand b to the shared ALU
- alu_f  out  3  function code to the shared ALU
- alu_y  in  WIDTH  result from the ALU
- alu_zero  in  1  zero flag from the ALU
- alu_carry_out  in  1  carry_out flag from the ALU
- alu_overflow  in  1  overflow flag from the ALU

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE and the round-robin pointer rr goes to 0.
  - All registered outputs clear: resp_valid, resp_y, resp_zero, resp_carry, resp_ovf, resp_err, resp_id, and the operand registers behind alu_a, alu_b, alu_f.
  - req_ready is 0 while in reset.
- Reset mid-operation (EXEC or RESP) drops the transaction silently. The requester must re-issue it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbiter picks the first i with req_valid[i]=1, searching i = rr, rr+1, … modulo NUM_REQ.
  - req_ready[i] is asserted combinationally for the winner only.
  - On the handshake, the operand registers capture req_a, req_b and req_f for i, resp_id <= i, rr <= (i+1) mod NUM_REQ, and the state goes to EXEC.
  - With no valid requests, the FSM stays in IDLE and rr is unchanged.
- EXEC:
  - alu_a, alu_b and alu_f are driven from the operand registers. They are held stable in every state and change only on grant.
  - At the clock edge, capture alu_y, alu_zero, alu_carry_out and alu_overflow into the response registers.
  - If alu_f = 3'b011: resp_y <= 0, resp_zero <= 1, resp_carry <= 0, resp_ovf <= 0, resp_err <= 1. Otherwise resp_err <= 0.
  - resp_valid[resp_id] <= 1 and the state goes to RESP.
- RESP:
  - resp_valid[resp_id] is held with all response fields stable until resp_ready[resp_id]=1.
  - On that handshake, resp_valid clears and the state goes to IDLE.
  - resp_ready from non-owners is ignored.
  - req_ready is 0 in EXEC and in RESP.
- Latency: request handshake at edge N, EXEC during cycle N+1, resp_valid high in cycle N+2. Minimum spacing is 3 cycles per transaction (IDLE, EXEC, RESP with immediate accept).
- Simultaneous requests: only one is granted per IDLE cycle. Losers must hold req_valid and their operands stable until granted.
- Fairness: any continuously asserted request is granted within NUM_REQ transactions.
- Response fields are not cleared after the handshake. They hold their last values, and only resp_valid qualifies them.

Test Plan:
- Reset, then single request: req 0 with a=16'h0005, b=16'h0003, f=010. Required: req_ready[0] the same cycle; resp_valid=4'b0001 two cycles later with resp_y=16'h0008, zero=0, carry=0, ovf=0, resp_id=0.
- Flags: a=16'h7FFF, b=16'h0001, f=010 -> y=16'h8000, ovf=1. Then a=16'h0003, b=16'h0003, f=110 -> y=0, zero=1. Then a=16'hFFFE, b=16'h0001, f=111 -> y=16'h0001.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0. Each resp_id matches its grant. No requester is granted twice before the others.
- Back-pressure: hold resp_ready[2]=0 for 5 cycles -> resp_valid and all response fields stable, req_ready=0 throughout. Assert resp_ready[2] -> IDLE the next cycle, next grant issued.
- Illegal op: f=011 with a=16'h1234, b=16'h5678 -> resp_y=0, resp_zero=1, resp_err=1, carry=0, ovf=0.
- Reset mid-op: drop reset_n during EXEC, release 2 cycles later -> all outputs 0, rr=0. A subsequent request from requester 3 is granted normally with correct result.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU among NUM_REQ
// requesters. The ALU result is captured and held until the owning requester accepts it.
module alu_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_f,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_y,
  output logic                     resp_zero,
  output logic                     resp_carry,
  output logic                     resp_ovf,
  output logic                     resp_err,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_f,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_zero,
  input  logic                     alu_carry_out,
  input  logic                     alu_overflow
);

  localparam logic [2:0] F_ILLEGAL = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, win, rr_next;
  logic             found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_f;
  logic [WIDTH-1:0] op_a_p0, op_b_p0;
  logic [2:0]       op_f_p0;
  logic             grant, resp_done;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] i);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_f = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
        sel_f = req_f[i*3 +: 3];
      end
    end
  end

  assign grant     = (state_q == IDLE) && found;
  assign resp_done = (state_q == RESP) && resp_ready[resp_id];
  assign rr_next   = (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;

  // Ready must stay low while reset is held, even though state already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (reset_n && grant) req_ready = onehot(win);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready[resp_id]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // p0: operands registered on grant, presented to the ALU during EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q       <= '0;
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_f_p0    <= '0;
      resp_id    <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      resp_zero  <= 1'b0;
      resp_carry <= 1'b0;
      resp_ovf   <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (grant) begin
        op_a_p0 <= sel_a;
        op_b_p0 <= sel_b;
        op_f_p0 <= sel_f;
        resp_id <= win;
        rr_q    <= rr_next;
      end
      // p1: ALU result captured at the end of EXEC and held through RESP.
      if (state_q == EXEC) begin
        resp_valid <= onehot(resp_id);
        if (op_f_p0 == F_ILLEGAL) begin
          resp_y     <= '0;
          resp_zero  <= 1'b1;
          resp_carry <= 1'b0;
          resp_ovf   <= 1'b0;
          resp_err   <= 1'b1;
        end else begin
          resp_y     <= alu_y;
          resp_zero  <= alu_zero;
          resp_carry <= alu_carry_out;
          resp_ovf   <= alu_overflow;
          resp_err   <= 1'b0;
        end
      end
      if (resp_done) resp_valid <= '0;
    end
  end

  assign alu_a = op_a_p0;
  assign alu_b = op_b_p0;
  assign alu_f = op_f_p0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached to the
// shared ALU port.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [11:0] req_f;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [15:0] resp_y;
  logic        resp_zero, resp_carry, resp_ovf, resp_err;
  logic [1:0]  resp_id;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;
  logic        alu_zero, alu_carry_out, alu_overflow;
  logic [16:0] sum;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.WIDTH(16), .NUM_REQ(4), .IDW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_f(req_f),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_y(resp_y), .resp_zero(resp_zero), .resp_carry(resp_carry),
    .resp_ovf(resp_ovf), .resp_err(resp_err), .resp_id(resp_id),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 000 AND, 001 OR, 010 ADD, 100 XOR, 101 NOR, 110 SUB, 111 SLT; 011 returns junk.
  always_comb begin
    sum           = '0;
    alu_y         = '0;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_f)
      3'b000: alu_y = alu_a & alu_b;
      3'b001: alu_y = alu_a | alu_b;
      3'b010: begin
        sum           = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y         = sum[15:0];
        alu_carry_out = sum[16];
        alu_overflow  = (alu_a[15] == alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      3'b100: alu_y = alu_a ^ alu_b;
      3'b101: alu_y = ~(alu_a | alu_b);
      3'b110: begin
        sum           = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_y         = sum[15:0];
        alu_carry_out = sum[16];
        alu_overflow  = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      3'b111: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      default: begin
        alu_y         = 16'hDEAD;
        alu_carry_out = 1'b1;
        alu_overflow  = 1'b1;
      end
    endcase
    alu_zero = (alu_y == 16'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] f);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_f[id*3 +: 3]   = f;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic single(input string tag, input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] f, input logic [15:0] ey,
                        input logic ez, input logic ec, input logic eo, input logic ee);
    @(posedge clk); #1;
    set_req(id, a, b, f);
    req_valid = 4'(1) << id;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(req_ready), 32'(4'(1) << id));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check({tag, "_exec_rdy"}, 32'(req_ready), 0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    check({tag, "_alu_f"}, 32'(alu_f), 32'(f));
    @(negedge clk);
    check({tag, "_vld"}, 32'(resp_valid), 32'(4'(1) << id));
    check({tag, "_id"}, 32'(resp_id), id);
    check({tag, "_y"}, 32'(resp_y), 32'(ey));
    check({tag, "_flags"}, 32'({resp_zero, resp_carry, resp_ovf, resp_err}),
          32'({ez, ec, eo, ee}));
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    reset_n    = 1'b0;
    req_valid  = 4'b0001;
    resp_ready = 4'hF;
    req_a      = '0;
    req_b      = '0;
    req_f      = '0;

    #12;
    check("rst_rdy", 32'(req_ready), 0);
    check("rst_vld", 32'(resp_valid), 0);
    check("rst_y", 32'(resp_y), 0);
    check("rst_alu", 32'({alu_a, alu_f}), 0);
    check("rst_fields", 32'({resp_zero, resp_carry, resp_ovf, resp_err, resp_id}), 0);
    req_valid = '0;
    @(posedge clk); #1 reset_n = 1'b1;

    single("add",  0, 16'h0005, 16'h0003, 3'b010, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    single("ovf",  1, 16'h7FFF, 16'h0001, 3'b010, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    single("sub",  2, 16'h0003, 16'h0003, 3'b110, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    single("slt",  0, 16'hFFFE, 16'h0001, 3'b111, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    single("ill",  3, 16'h1234, 16'h5678, 3'b011, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // Round-robin with all four requesters valid from reset.
    reset_pulse();
    for (int i = 0; i < 4; i++) set_req(i, 16'(16'h0010 * (i + 1)), 16'h0001, 3'b010);
    req_valid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      e = t % 4;
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(4'(1) << e));
      @(negedge clk);
      check("rr_exec_rdy", 32'(req_ready), 0);
      @(negedge clk);
      check("rr_vld", 32'(resp_valid), 32'(4'(1) << e));
      check("rr_id", 32'(resp_id), e);
      check("rr_y", 32'(resp_y), 32'(16'h0010 * (e + 1) + 1));
    end
    @(posedge clk); #1 req_valid = '0;

    // Back-pressure on requester 2 while requester 1 waits.
    @(posedge clk); #1;
    set_req(2, 16'h00FF, 16'h0F0F, 3'b000);
    set_req(1, 16'h000F, 16'h00F0, 3'b001);
    resp_ready = 4'b1011;
    req_valid  = 4'b0100;
    @(negedge clk);
    check("bp_rdy", 32'(req_ready), 32'h4);
    @(posedge clk); #1 req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("bp_vld", 32'(resp_valid), 32'h4);
        check("bp_y", 32'(resp_y), 32'h000F);
        check("bp_id", 32'(resp_id), 2);
      end
      check("bp_rdy_low", 32'(req_ready), 0);
    end
    @(posedge clk); #1 resp_ready = 4'hF;
    @(negedge clk);
    check("bp_hold_last", 32'(resp_valid), 32'h4);
    @(negedge clk);
    check("bp_released", 32'(resp_valid), 0);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_id", 32'(resp_id), 1);
    check("bp_next_y", 32'(resp_y), 32'h00FF);
    @(posedge clk);

    // Reset during EXEC drops the transaction and returns rr to 0.
    @(posedge clk); #1;
    set_req(1, 16'h00AA, 16'h0055, 3'b001);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_alu_a", 32'(alu_a), 0);
    check("mid_rst_vld", 32'(resp_valid), 0);
    check("mid_rst_rdy", 32'(req_ready), 0);
    check("mid_rst_y", 32'(resp_y), 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("post_rst_vld", 32'(resp_valid), 0);
    check("post_rst_alu", 32'({alu_a, alu_b, alu_f}), 0);
    req_valid = 4'b1010;
    #1;
    check("post_rst_rr", 32'(req_ready), 32'h2);
    req_valid = '0;
    single("req3", 3, 16'h00F0, 16'h0F0F, 3'b100, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
